mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
Multicycle control FSM that sequences the shared single-memory MIPS datapath one step per clock: fetch, decode, execute, memory, writeback. It decodes op/funct and drives every mux select and write enable of the datapath. It also stalls on a memory-ready handshake and reports completion, illegal-instruction and memory-timeout status. It sits beside the datapath inside the multicycle CPU top and replaces the single-cycle combinational control unit.

Parameters:
TIMEOUT, 16, max consecutive cycles a memory state may wait for mem_ready before mem_timeout is raised (must be >= 1).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
op  input  6  instruction[31:26] from the instruction register
funct  input  6  instruction[5:0]
zero  input  1  ALU zero flag
mem_ready  input  1  memory has completed the current read/write this cycle
iord  output  1  memory address select: 0=PC, 1=ALUOut
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register load
pcen  output  1  PC load = pcwrite | (branch & zero)
regwrite  output  1  register file write enable
regdst  output  1  write-address select: 0=rt, 1=rd
memtoreg  output  1  writeback select: 0=ALUOut, 1=memory data
alusrca  output  1  ALU A select: 0=PC, 1=rs
alusrcb  output  2  ALU B select: 00=rt, 01=const 4, 10=immext, 11=immext<<2
pcsrc  output  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target
alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
instr_done  output  1  one-cycle pulse in the last cycle of a retired instruction
illegal  output  1  one-cycle pulse when op or funct is unsupported
mem_timeout  output  1  sticky; set when a memory wait exceeds TIMEOUT

Behaviour:
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Supported R-type funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- Moore outputs decode from state only. pcen additionally uses zero; instr_done and illegal also use op/funct/mem_ready. Unlisted outputs are 0; unlisted alucontrol is 010.
- While rst=0: state=FETCH; pcen, irwrite, regwrite, memwrite, instr_done, illegal forced to 0; mem_timeout=0; wait counter=0. Other outputs show their FETCH values.
- FETCH: iord=0, alusrca=0, alusrcb=01, pcsrc=00.
  - irwrite and pcen asserted only when mem_ready=1, then go to DECODE.
  - Otherwise hold in FETCH.
- DECODE: alusrca=0, alusrcb=11 (branch target into ALUOut). Next state by op:
  - lw/sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
  - Any other op -> FETCH with illegal=1.
- MEMADR: alusrca=1, alusrcb=10, add. Go to MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1, then FETCH.
- MEMWRITE: iord=1, memwrite=1, held high every cycle until mem_ready. On mem_ready: instr_done=1, then FETCH.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct.
  - Unknown funct: illegal=1, go to FETCH, no writeback.
  - Otherwise go to ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1, then FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, branch=1, pcsrc=01, instr_done=1, then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add, then ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1, then FETCH.
- JUMP: pcsrc=10, pcwrite=1, instr_done=1, then FETCH.
- Latency with mem_ready tied high: beq 3, j 3, R-type 4, addi 4, sw 4, lw 5 cycles.
- Memory wait handling:
  - Wait states are FETCH, MEMREAD and MEMWRITE.
  - A counter of width $clog2(TIMEOUT+1) increments each cycle the FSM sits in a wait state with mem_ready=0.
  - It clears on mem_ready=1 or on leaving the wait state, and saturates at TIMEOUT.
  - On reaching TIMEOUT, mem_timeout sets. It stays set until reset, and the FSM keeps waiting.
- Reset asserted mid-instruction aborts it immediately. No partial writeback occurs after deassertion; execution restarts at FETCH.
- A mem_ready pulse in a non-wait state has no effect.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state_t enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
  - opcode and funct localparams.
  - alucontrol code localparams.
  - aluop_t: ADD, SUB, FUNCT.
- One sub-module, mc_aludec: combinational aluop+funct -> alucontrol plus a funct_valid flag.
- The state register, next-state logic, output decode and timeout counter stay in mc_controller.

Test Plan:
- Release reset with mem_ready=1 and op=000000, funct=100000: FETCH(irwrite=1, pcen=1) -> DECODE -> EXECUTE(alucontrol=010) -> ALUWB(regwrite=1, regdst=1, instr_done=1) -> FETCH; 4 cycles total.
- lw (op=100011) with mem_ready low for 3 cycles in MEMREAD: iord=1 held 4 cycles, then MEMWB with memtoreg=1 and regwrite=1; instr_done after 8 cycles total.
- beq (op=000100): zero=1 in BRANCH gives pcen=1, pcsrc=01; zero=0 gives pcen=0; instr_done=1 in both cases.
- op=111111 in DECODE, then funct=000111 with op=000000 in EXECUTE: illegal pulses once each, return to FETCH, regwrite never asserted, instr_done=0.
- TIMEOUT=16 with mem_ready=0 in FETCH: mem_timeout=0 through the 15th wait cycle, 1 from the 16th onward. Stays 1 after mem_ready and subsequent instructions; cleared only by rst=0.
- Assert rst=0 during MEMWRITE with memwrite=1: memwrite drops the same cycle (asynchronous). After release, state=FETCH and no memwrite or regwrite appears until a new sw reaches MEMWRITE.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encoding,
// opcode/funct values, ALU control codes, the ALU-operation class seen by
// the ALU decoder, and small decode helpers.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTE,
    ALUWB,
    BRANCH,
    ADDIEX,
    ADDIWB,
    JUMP
  } state_t;

  typedef enum logic [1:0] {
    ADD,
    SUB,
    FUNCT
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // States that stall on the memory-ready handshake.
  function automatic logic is_wait_state(input state_t s);
    return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the ALU-operation class and the R-type funct field to
// the 3-bit ALU control code.
//   aluop       : ADD / SUB forced by the FSM, FUNCT = use funct field
//   funct       : instruction[5:0]
//   alucontrol  : ALU operation code (add when nothing else applies)
//   funct_valid : funct is one of the supported R-type operations
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_valid
);

  logic [2:0] funct_code;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    funct_code  = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FUNCT_ADD: funct_code = ALU_ADD;
      FUNCT_SUB: funct_code = ALU_SUB;
      FUNCT_AND: funct_code = ALU_AND;
      FUNCT_OR:  funct_code = ALU_OR;
      FUNCT_SLT: funct_code = ALU_SLT;
      default:   funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      SUB:     alucontrol = ALU_SUB;
      FUNCT:   alucontrol = funct_code;
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM. Sequences the shared-memory datapath one step
// per clock and drives all of its mux selects and write enables.
//   clk, rst         : clock (rising edge), asynchronous active-low reset
//   op, funct, zero  : instruction fields from the IR, ALU zero flag
//   mem_ready        : memory finished the current access this cycle
//   iord .. alucontrol: datapath selects and strobes
//   instr_done       : pulse in the final cycle of a retired instruction
//   illegal          : pulse when op or funct is unsupported
//   mem_timeout      : sticky flag, a memory wait reached TIMEOUT cycles
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_timeout
);

  localparam int             CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_MAX    = CW'(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);

  state_t        state, state_next;
  aluop_t        aluop;
  logic          funct_valid;
  logic          pcwrite, branch;
  logic          irwrite_raw, regwrite_raw, memwrite_raw;
  logic          done_raw, illegal_raw;
  logic [CW-1:0] wait_cnt;

  mc_aludec u_aludec (
    .aluop       (aluop),
    .funct       (funct),
    .alucontrol  (alucontrol),
    .funct_valid (funct_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) state_next = MEMWB;
      MEMWRITE: if (mem_ready) state_next = FETCH;
      EXECUTE:  state_next = funct_valid ? ALUWB : FETCH;
      ADDIEX:   state_next = ADDIWB;
      default:  state_next = FETCH;
    endcase
  end

  always_comb begin
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    regwrite_raw = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = ADD;
    done_raw     = 1'b0;
    illegal_raw  = 1'b0;
    case (state)
      FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcwrite     = mem_ready;
      end
      DECODE: begin
        alusrcb     = 2'b11;
        illegal_raw = !(op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMREAD:  iord = 1'b1;
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      MEMWRITE: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        done_raw     = mem_ready;
      end
      EXECUTE: begin
        alusrca     = 1'b1;
        aluop       = FUNCT;
        illegal_raw = !funct_valid;
      end
      ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        aluop    = SUB;
        branch   = 1'b1;
        pcsrc    = 2'b01;
        done_raw = 1'b1;
      end
      ADDIWB: begin
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      JUMP: begin
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        done_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset directly so they drop the instant reset is
  // asserted, not at the next edge.
  assign pcen       = rst & (pcwrite | (branch & zero));
  assign irwrite    = rst & irwrite_raw;
  assign regwrite   = rst & regwrite_raw;
  assign memwrite   = rst & memwrite_raw;
  assign instr_done = rst & done_raw;
  assign illegal    = rst & illegal_raw;

  // Wait counter: counts stalled cycles in a wait state, saturating at
  // TIMEOUT. The flag sets on the edge where the count reaches TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (is_wait_state(state) && !mem_ready) begin
      if (wait_cnt != CNT_MAX)   wait_cnt    <= wait_cnt + CNT_ONE;
      if (wait_cnt >= CNT_LAST)  mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: a table of per-cycle vectors
// walking every instruction class, plus hand-written sequences for reset,
// memory timeout and reset abort during a store.
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  logic       clk, rst;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       instr_done, illegal, mem_timeout;

  int checks = 0;
  int errors = 0;

  mc_controller #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .instr_done(instr_done),
    .illegal(illegal), .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic       iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done, illegal;
  } out_t;

  typedef struct {
    logic       mem_ready;
    logic [5:0] op, funct;
    logic       zero;
    out_t       exp;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  function automatic out_t sample();
    return {iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca,
            alusrcb, pcsrc, alucontrol, instr_done, illegal};
  endfunction

  // Hand-derived expected outputs per FSM step.
  function automatic out_t base();
    out_t e = '0;
    e.alucontrol = 3'b010;
    return e;
  endfunction
  function automatic out_t e_fetch(input logic mr);
    out_t e = base(); e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; return e;
  endfunction
  function automatic out_t e_decode(input logic ill);
    out_t e = base(); e.alusrcb = 2'b11; e.illegal = ill; return e;
  endfunction
  function automatic out_t e_exec(input logic [2:0] alu, input logic ill);
    out_t e = base(); e.alusrca = 1'b1; e.alucontrol = alu; e.illegal = ill; return e;
  endfunction
  function automatic out_t e_aluwb();
    out_t e = base(); e.regwrite = 1'b1; e.regdst = 1'b1; e.instr_done = 1'b1; return e;
  endfunction
  function automatic out_t e_adr();  // MEMADR and ADDIEX look identical
    out_t e = base(); e.alusrca = 1'b1; e.alusrcb = 2'b10; return e;
  endfunction
  function automatic out_t e_memread();
    out_t e = base(); e.iord = 1'b1; return e;
  endfunction
  function automatic out_t e_memwb();
    out_t e = base(); e.regwrite = 1'b1; e.memtoreg = 1'b1; e.instr_done = 1'b1; return e;
  endfunction
  function automatic out_t e_memwrite(input logic mr);
    out_t e = base(); e.iord = 1'b1; e.memwrite = 1'b1; e.instr_done = mr; return e;
  endfunction
  function automatic out_t e_branch(input logic z);
    out_t e = base(); e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
    e.pcen = z; e.instr_done = 1'b1; return e;
  endfunction
  function automatic out_t e_addiwb();
    out_t e = base(); e.regwrite = 1'b1; e.instr_done = 1'b1; return e;
  endfunction
  function automatic out_t e_jump();
    out_t e = base(); e.pcsrc = 2'b10; e.pcen = 1'b1; e.instr_done = 1'b1; return e;
  endfunction

  task automatic add(input logic mr, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input out_t e, input string tag);
    vec_t v;
    v.mem_ready = mr; v.op = o; v.funct = f; v.zero = z; v.exp = e; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_table();
    logic [5:0] fs[5];
    logic [2:0] as[5];
    fs = '{FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT};
    as = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    for (int i = 0; i < 5; i++) begin
      add(1, OP_RTYPE, fs[i], 0, e_fetch(1),       "r_fetch");
      add(1, OP_RTYPE, fs[i], 0, e_decode(0),      "r_decode");
      add(1, OP_RTYPE, fs[i], 0, e_exec(as[i], 0), "r_exec");
      add(1, OP_RTYPE, fs[i], 0, e_aluwb(),        "r_aluwb");
    end
    add(0, OP_ADDI, 6'd0, 0, e_fetch(0),  "fetch_stall");
    add(1, OP_ADDI, 6'd0, 0, e_fetch(1),  "addi_fetch");
    add(1, OP_ADDI, 6'd0, 0, e_decode(0), "addi_decode");
    add(1, OP_ADDI, 6'd0, 0, e_adr(),     "addi_ex");
    add(1, OP_ADDI, 6'd0, 0, e_addiwb(),  "addi_wb");
    add(1, OP_J, 6'd0, 0, e_fetch(1),  "j_fetch");
    add(1, OP_J, 6'd0, 0, e_decode(0), "j_decode");
    add(1, OP_J, 6'd0, 0, e_jump(),    "j_jump");
    add(1, OP_BEQ, 6'd0, 1, e_fetch(1),  "beq1_fetch");
    add(1, OP_BEQ, 6'd0, 1, e_decode(0), "beq1_decode");
    add(1, OP_BEQ, 6'd0, 1, e_branch(1), "beq1_taken");
    add(1, OP_BEQ, 6'd0, 0, e_fetch(1),  "beq0_fetch");
    add(1, OP_BEQ, 6'd0, 0, e_decode(0), "beq0_decode");
    add(1, OP_BEQ, 6'd0, 0, e_branch(0), "beq0_not_taken");
    add(1, OP_SW, 6'd0, 0, e_fetch(1),    "sw_fetch");
    add(1, OP_SW, 6'd0, 0, e_decode(0),   "sw_decode");
    add(1, OP_SW, 6'd0, 0, e_adr(),       "sw_memadr");
    add(1, OP_SW, 6'd0, 0, e_memwrite(1), "sw_memwrite");
    add(1, OP_SW, 6'd0, 0, e_fetch(1),    "swW_fetch");
    add(1, OP_SW, 6'd0, 0, e_decode(0),   "swW_decode");
    add(1, OP_SW, 6'd0, 0, e_adr(),       "swW_memadr");
    add(0, OP_SW, 6'd0, 0, e_memwrite(0), "swW_wait1");
    add(0, OP_SW, 6'd0, 0, e_memwrite(0), "swW_wait2");
    add(1, OP_SW, 6'd0, 0, e_memwrite(1), "swW_done");
    // lw with mem_ready low outside wait states and for 3 MEMREAD cycles
    add(1, OP_LW, 6'd0, 0, e_fetch(1),  "lw_fetch");
    add(0, OP_LW, 6'd0, 0, e_decode(0), "lw_decode");
    add(0, OP_LW, 6'd0, 0, e_adr(),     "lw_memadr");
    add(0, OP_LW, 6'd0, 0, e_memread(), "lw_wait1");
    add(0, OP_LW, 6'd0, 0, e_memread(), "lw_wait2");
    add(0, OP_LW, 6'd0, 0, e_memread(), "lw_wait3");
    add(1, OP_LW, 6'd0, 0, e_memread(), "lw_read");
    add(0, OP_LW, 6'd0, 0, e_memwb(),   "lw_memwb");
    add(1, 6'b111111, 6'd0, 0, e_fetch(1),  "badop_fetch");
    add(1, 6'b111111, 6'd0, 0, e_decode(1), "badop_decode");
    add(1, OP_RTYPE, 6'b000111, 0, e_fetch(1),        "badfn_fetch");
    add(1, OP_RTYPE, 6'b000111, 0, e_decode(0),       "badfn_decode");
    add(1, OP_RTYPE, 6'b000111, 0, e_exec(3'b010, 1), "badfn_exec");
    add(1, OP_RTYPE, FUNCT_ADD, 0, e_fetch(1),        "recover_fetch");
    add(1, OP_RTYPE, FUNCT_ADD, 0, e_decode(0),       "recover_decode");
    add(1, OP_RTYPE, FUNCT_ADD, 0, e_exec(3'b010, 0), "recover_exec");
    add(1, OP_RTYPE, FUNCT_ADD, 0, e_aluwb(),         "recover_aluwb");
  endtask

  initial begin
    rst = 1'b0; mem_ready = 1'b1; op = OP_RTYPE; funct = FUNCT_ADD; zero = 1'b0;
    build_table();
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", 32'(sample()), 32'(e_fetch(0)));
    check("reset_timeout", 32'(mem_timeout), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven walk: positioned just after a negedge, state is stable.
    for (int i = 0; i < vecs.size(); i++) begin
      mem_ready = vecs[i].mem_ready; op = vecs[i].op;
      funct = vecs[i].funct;         zero = vecs[i].zero;
      #1;
      check(vecs[i].tag, 32'(sample()), 32'(vecs[i].exp));
      @(negedge clk);
    end
    check("table_no_timeout", 32'(mem_timeout), 32'd0);

    // Memory timeout in FETCH.
    rst = 1'b0; mem_ready = 1'b0; op = OP_RTYPE; funct = FUNCT_ADD;
    @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      #1;
      check($sformatf("timeout_cycle%0d", n), 32'(mem_timeout), (n >= 16) ? 32'd1 : 32'd0);
    end
    check("timeout_still_waiting", 32'(sample()), 32'(e_fetch(0)));
    mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("timeout_rtype_retired", 32'(sample()), 32'(e_fetch(1)));
    check("timeout_sticky", 32'(mem_timeout), 32'd1);
    rst = 1'b0;
    #1;
    check("timeout_cleared_by_reset", 32'(mem_timeout), 32'd0);

    // Reset abort during MEMWRITE.
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1; op = OP_SW; funct = 6'd0;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("abort_memwrite_high", 32'(memwrite), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("abort_memwrite_drop", 32'(memwrite), 32'd0);
    check("abort_reset_outputs", 32'(sample()), 32'(e_fetch(0)));
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("abort_idle%0d", k), 32'(sample()), 32'(e_fetch(0)));
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1; check("abort_new_fetch",  32'(sample()), 32'(e_fetch(1)));     @(negedge clk);
    #1; check("abort_new_decode", 32'(sample()), 32'(e_decode(0)));    @(negedge clk);
    #1; check("abort_new_memadr", 32'(sample()), 32'(e_adr()));        @(negedge clk);
    #1; check("abort_new_memwr",  32'(sample()), 32'(e_memwrite(1)));
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
